// File: rtl/uart_byte_rx.sv
// UART 8N1 receiver: 2-FF synchronised rx, oversampled bit timing, valid/ready byte output.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample tick.
module uart_byte_rx #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       rx_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned DIV_RAW = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W   = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    WaitHigh,
    Idle,
    Start,
    Data,
    Stop
  } state_e;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;

  logic [1:0]       sync_q, sync_d;
  logic             rx_level;
  logic             rx_sample;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitn_q, bitn_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_done;
  logic             frame_err;

  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  // Free-running divider; with DIV==1 every clock is a tick.
  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
  end

  always_comb begin
    sync_d = {sync_q[0], rx_i};
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      div_cnt_q <= '0;
      sync_q    <= 2'b11;
    end else begin
      div_cnt_q <= div_cnt_d;
      sync_q    <= sync_d;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // The FSM runs one tick behind the synchroniser so that the nominal sample
  // point has a neighbour on each side for the vote.
  logic [1:0] rx_hist_q, rx_hist_d;

  always_comb begin
    rx_hist_d = rx_hist_q;
    if (tick) begin
      rx_hist_d = {rx_hist_q[0], sync_q[1]};
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_hist_q <= 2'b11;
    end else begin
      rx_hist_q <= rx_hist_d;
    end
  end

  always_comb begin
    rx_level  = rx_hist_q[0];
    rx_sample = (sync_q[1] & rx_hist_q[0]) |
                (sync_q[1] & rx_hist_q[1]) |
                (rx_hist_q[0] & rx_hist_q[1]);
  end
`else
  always_comb begin
    rx_level  = sync_q[1];
    rx_sample = sync_q[1];
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitn_d    = bitn_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_err = 1'b0;
    if (tick) begin
      case (state_q)
        WaitHigh: begin
          if (rx_level) begin
            state_d = Idle;
          end
        end
        Idle: begin
          if (!rx_level) begin
            cnt_d   = '0;
            state_d = Start;
          end
        end
        Start: begin
          if (cnt_q == CNT_MID) begin
            if (rx_sample) begin
              state_d = Idle;
            end else begin
              cnt_d   = '0;
              bitn_d  = '0;
              state_d = Data;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        Data: begin
          if (cnt_q == CNT_LAST) begin
            shift_d = {rx_sample, shift_q[7:1]};
            cnt_d   = '0;
            if (bitn_q == 3'd7) begin
              state_d = Stop;
            end else begin
              bitn_d = bitn_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        Stop: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rx_sample) begin
              byte_done = 1'b1;
              state_d   = Idle;
            end else begin
              // A held-low line parks in WaitHigh, so a break reports once.
              frame_err = 1'b1;
              state_d   = WaitHigh;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = WaitHigh;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= WaitHigh;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
    end
  end

  // A completed byte may replace the held one only if it leaves this cycle.
  always_comb begin
    valid_d     = valid_q;
    data_d      = data_q;
    overrun_d   = 1'b0;
    frame_err_d = frame_err;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (byte_done) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule
